// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: instruction constants, memory defaults and
// the fetch FSM state and buffer entry types.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
   localparam int unsigned DEF_MEM_BYTES = 4096;
   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between fetch and decode. The head is a register
// and reads back as 0/NOP while the buffer is empty.
module fetch_fifo
   import riscv_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  fetch_entry_t i_din,
   input  logic         i_pop,
   input  logic         i_flush,
   output logic         o_valid,
   output logic [31:0]  o_pc,
   output logic [31:0]  o_instr,
   output logic [1:0]   o_count
);

   logic [1:0]   r_count;
   fetch_entry_t r_head;
   fetch_entry_t r_tail;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else if (i_push && !i_pop) begin
         r_count <= r_count + 2'd1;
      end else if (!i_push && i_pop) begin
         r_count <= r_count - 2'd1;
      end
   end

   // Payload registers carry no reset; r_count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (i_push && ((r_count == 2'd0) || ((r_count == 2'd1) && i_pop))) begin
         r_head <= i_din;
      end else if (i_pop) begin
         r_head <= r_tail;
      end
      if (i_push) begin
         r_tail <= i_din;
      end
   end

   assign o_valid = (r_count != 2'd0);
   assign o_pc    = o_valid ? r_head.pc    : 32'h0000_0000;
   assign o_instr = o_valid ? r_head.instr : NOP_INSTR;
   assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, reads inst_mem combinationally and feeds
// decode through a 2-entry buffer, trapping into FAULT on any invalid fetch address.
module inst_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] PC,
   input  logic [31:0] Instruction_Code,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fetch_fault
);

   localparam logic [31:0] LP_MEM_LIMIT = 32'(MEM_BYTES);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic [31:0]  w_pc_inc;
   logic [1:0]   w_count;
   logic         w_pop;
   logic         w_space;
   logic         w_fetch;
   fetch_entry_t w_entry;

   // Word aligned and inside the memory; bit 31 set is simply out of range.
   function automatic logic addr_ok(input logic [31:0] addr);
      return (addr[1:0] == 2'b00) && (addr < LP_MEM_LIMIT);
   endfunction

   assign w_pop    = out_valid && out_ready;
   assign w_space  = (w_count != 2'd2) || w_pop;
   assign w_fetch  = (r_state == RUN) && w_space && !redirect_valid;
   assign w_pc_inc = r_pc + 32'd4;
   assign w_entry  = '{pc: r_pc, instr: Instruction_Code};

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      if (redirect_valid) begin
         w_pc_nxt    = redirect_pc;
         w_state_nxt = addr_ok(redirect_pc) ? RUN : FAULT;
      end else if (w_fetch) begin
         w_pc_nxt = w_pc_inc;
         if (!addr_ok(w_pc_inc)) begin
            w_state_nxt = FAULT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   fetch_fifo u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_fetch),
      .i_din   (w_entry),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_valid (out_valid),
      .o_pc    (out_pc),
      .o_instr (out_instr),
      .o_count (w_count)
   );

   assign PC          = r_pc;
   assign fetch_fault = (r_state == FAULT);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the fetch buffer.
module tb_inst_fetch;

   localparam int unsigned MEMB = 4096;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC;
   logic [31:0] Instruction_Code;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fetch_fault;

   logic [31:0] mem [0:1023];

   int checks = 0;
   int errors = 0;

   ent_t        mq[$];
   logic [31:0] m_pc;
   logic        m_fault;

   always #5 clk = ~clk;

   inst_fetch dut (
      .clk              (clk),
      .reset            (reset),
      .PC               (PC),
      .Instruction_Code (Instruction_Code),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instr        (out_instr),
      .out_pc           (out_pc),
      .fetch_fault      (fetch_fault)
   );

   function automatic logic [31:0] imem(input logic [31:0] addr);
      return (addr < MEMB) ? mem[addr[11:2]] : 32'hDEAD_BEEF;
   endfunction

   assign Instruction_Code = imem(PC);

   function automatic logic target_ok(input logic [31:0] a);
      return (a % 4 == 0) && (a < MEMB);
   endfunction

   // One clock of the reference model, from the inputs presented at the edge.
   function automatic void model_step();
      bit popped;
      if (reset) begin
         mq.delete();
         m_pc    = 32'h0;
         m_fault = 1'b0;
         return;
      end
      popped = (mq.size() > 0) && out_ready;
      if (redirect_valid) begin
         mq.delete();
         m_pc    = redirect_pc;
         m_fault = !target_ok(redirect_pc);
         return;
      end
      if (popped) void'(mq.pop_front());
      if (!m_fault && mq.size() < 2) begin
         mq.push_back('{pc: m_pc, instr: imem(m_pc)});
         m_pc = m_pc + 32'd4;
         if (m_pc >= MEMB) m_fault = 1'b1;
      end
   endfunction

   function automatic logic [97:0] exp_vec();
      if (mq.size() > 0) return {1'b1, mq[0].pc, mq[0].instr, m_pc, m_fault};
      return {1'b0, 32'h0, 32'h0000_0013, m_pc, m_fault};
   endfunction

   function automatic logic [97:0] act_vec();
      return {out_valid, out_pc, out_instr, PC, fetch_fault};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b1;
      tick();
      tick();
      checks++;
      if ({out_valid, out_instr, out_pc, PC, fetch_fault} !== {1'b0, 32'h13, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: got v=%0b instr=%h pc=%h PC=%h fault=%0b", out_valid, out_instr, out_pc, PC, fetch_fault);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      bit seen18 = 0;
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stream_model: cyc %0d got %h want %h", k, act_vec(), exp_vec());
         end
         checks++;
         if (PC !== 32'(4 * (k + 1))) begin
            errors++;
            $display("FAIL stream_pc: cyc %0d got %h want %h", k, PC, 32'(4 * (k + 1)));
         end
         if (k == 0) begin
            checks++;
            if (!out_valid || out_pc !== 32'h0 || out_instr !== 32'h0080_1083) begin
               errors++;
               $display("FAIL first_handshake: got v=%0b pc=%h instr=%h want 1/0/00801083", out_valid, out_pc, out_instr);
            end
         end
         if (out_valid && out_pc == 32'h18) begin
            seen18 = 1;
            checks++;
            if (out_instr !== 32'h0051_0463) begin
               errors++;
               $display("FAIL instr_at_18: got %h want 00510463", out_instr);
            end
         end
      end
      checks++;
      if (!seen18) begin
         errors++;
         $display("FAIL stream_reach_18: got not-seen want seen");
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] got[$];
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if (PC !== 32'h8 || out_pc !== 32'h0 || !out_valid) begin
         errors++;
         $display("FAIL backpressure_hold: got PC=%h out_pc=%h v=%0b want 8/0/1", PC, out_pc, out_valid);
      end
      checks++;
      if (act_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL backpressure_model: got %h want %h", act_vec(), exp_vec());
      end
      for (int k = 0; k < 6; k++) begin
         out_ready = 1'b1;
         if (out_valid) got.push_back(out_pc);
         tick();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL release_model: cyc %0d got %h want %h", k, act_vec(), exp_vec());
         end
      end
      checks++;
      if (got.size() < 3) begin
         errors++;
         $display("FAIL release_count: got %0d want >=3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== 32'(4 * i)) begin
               errors++;
               $display("FAIL release_order: idx %0d got %h want %h", i, got[i], 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_redirect_full();
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || PC !== 32'h100) begin
         errors++;
         $display("FAIL redirect_bubble: got v=%0b PC=%h want 0/100", out_valid, PC);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h13) begin
         errors++;
         $display("FAIL redirect_target: got v=%0b pc=%h instr=%h want 1/100/00000013", out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_misaligned();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h5;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (fetch_fault !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_fault: got fault=%0b v=%0b want 1/0", fetch_fault, out_valid);
      end
      for (int k = 0; k < 3; k++) tick();
      checks++;
      if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || PC !== 32'h5) begin
         errors++;
         $display("FAIL fault_hold: got fault=%0b v=%0b PC=%h want 1/0/5", fetch_fault, out_valid, PC);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h18;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (fetch_fault !== 1'b0) begin
         errors++;
         $display("FAIL fault_clear: got %0b want 0", fetch_fault);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h0051_0463) begin
         errors++;
         $display("FAIL recover_instr: got v=%0b instr=%h want 1/00510463", out_valid, out_instr);
      end
   endtask

   task automatic test_boundary();
      int vis = 0;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'hFFC || PC !== 32'h1000 || fetch_fault !== 1'b1) begin
         errors++;
         $display("FAIL boundary_last: got v=%0b pc=%h PC=%h fault=%0b want 1/ffc/1000/1", out_valid, out_pc, PC, fetch_fault);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         if (out_valid) vis++;
      end
      checks++;
      if (vis != 0 || PC !== 32'h1000 || fetch_fault !== 1'b1) begin
         errors++;
         $display("FAIL boundary_stop: got valid_cycles=%0d PC=%h fault=%0b want 0/1000/1", vis, PC, fetch_fault);
      end
   endtask

   task automatic test_reset_redirect();
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      reset          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      tick();
      checks++;
      if ({out_valid, out_instr, out_pc, PC, fetch_fault} !== {1'b0, 32'h13, 32'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_over_redirect: got v=%0b instr=%h pc=%h PC=%h fault=%0b", out_valid, out_instr, out_pc, PC, fetch_fault);
      end
      reset          = 1'b0;
      redirect_valid = 1'b0;
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         out_ready      = ($urandom_range(0, 9) < 7);
         reset          = ($urandom_range(0, 199) == 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         r = $urandom_range(0, 9);
         case (r)
            0:       redirect_pc = 32'hFFC;
            1:       redirect_pc = {$urandom_range(0, 1023), 2'b00} | 32'h1;
            2:       redirect_pc = 32'h8000_0000 | {$urandom_range(0, 1023), 2'b00};
            3:       redirect_pc = 32'h1000;
            default: redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
         endcase
         tick();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_model: cyc %0d got %h want %h", k, act_vec(), exp_vec());
         end
      end
      reset          = 1'b0;
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0]  = 32'h0080_1083;
      mem[6]  = 32'h0051_0463;
      mem[64] = 32'h0000_0013;
      out_ready = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_misaligned();
      test_boundary();
      test_reset_redirect();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
